// File: rtl/pll_seq_pkg.sv
// Shared types and width helpers for the PLL lock sequencer.
package pll_seq_pkg;

    // Sequencer states, from PLL reset pulse through supervised run.
    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    // Width of the shared cycle counter: enough bits for the longest of
    // the three timed phases (never below one bit).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        m = (m < 2) ? 2 : m;
        return $clog2(m);
    endfunction

    // Width of the retry counter; kept at one bit or more so that a
    // MAX_RETRIES of zero still yields a legal vector.
    function automatic int retry_width(input int max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level, resets to 0.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings the rPLL from power-up to a clean core reset release and keeps
// supervising LOCK afterwards. Runs entirely on the board reference clock.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  pll_lock_i,
    input  logic                                  force_relock_i,
    output logic                                  pll_reset_o,
    output logic                                  sys_rst_n_o,
    output logic                                  ready_o,
    output logic                                  fault_o,
    output logic [retry_width(MAX_RETRIES)-1:0]   retry_count_o,
    output logic [7:0]                            lock_loss_count_o
);

    localparam int CNT_W   = cnt_width(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int RETRY_W = retry_width(MAX_RETRIES);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1'b1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_ZERO   = {RETRY_W{1'b0}};
    localparam logic [RETRY_W-1:0] RETRY_ONE    = RETRY_W'(1'b1);

    logic               lock_s;
    pll_state_e         state_r;
    pll_state_e         state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [RETRY_W-1:0] retry_nxt_s;
    logic [7:0]         loss_nxt_s;

    // LOCK is asynchronous to clk; nothing else looks at pll_lock_i.
    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock_i),
        .q     (lock_s)
    );

    // State and shared phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= PLL_RST;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state, counter, retry and lock-loss bookkeeping; a relock
    // request overrides every other transition.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        retry_nxt_s = retry_count_o;
        loss_nxt_s  = lock_loss_count_o;
        if (force_relock_i) begin
            state_nxt_s = PLL_RST;
            cnt_nxt_s   = CNT_ZERO;
            retry_nxt_s = RETRY_ZERO;
        end else begin
            case (state_r)
                PLL_RST: begin
                    if (cnt_r == RST_LAST) begin
                        state_nxt_s = WAIT_LOCK;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt_s = STABLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        cnt_nxt_s = CNT_ZERO;
                        if (retry_count_o == RETRY_MAX) begin
                            state_nxt_s = FAULT;
                        end else begin
                            state_nxt_s = PLL_RST;
                            retry_nxt_s = retry_count_o + RETRY_ONE;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                STABLE: begin
                    // A glitch restarts the lock wait without costing a retry.
                    if (!lock_s) begin
                        state_nxt_s = WAIT_LOCK;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_nxt_s = RUN;
                        cnt_nxt_s   = CNT_ZERO;
                        retry_nxt_s = RETRY_ZERO;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_nxt_s = PLL_RST;
                        cnt_nxt_s   = CNT_ZERO;
                        if (lock_loss_count_o != 8'hFF) begin
                            loss_nxt_s = lock_loss_count_o + 8'd1;
                        end else begin
                            loss_nxt_s = lock_loss_count_o;
                        end
                    end else begin
                        cnt_nxt_s = CNT_ZERO;
                    end
                end
                FAULT: begin
                    state_nxt_s = FAULT;
                    cnt_nxt_s   = CNT_ZERO;
                end
                default: begin
                    state_nxt_s = PLL_RST;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so they move with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_reset_o       <= 1'b1;
            sys_rst_n_o       <= 1'b0;
            ready_o           <= 1'b0;
            fault_o           <= 1'b0;
            retry_count_o     <= RETRY_ZERO;
            lock_loss_count_o <= 8'd0;
        end else begin
            pll_reset_o       <= (state_nxt_s == PLL_RST) || (state_nxt_s == FAULT);
            sys_rst_n_o       <= (state_nxt_s == RUN);
            ready_o           <= (state_nxt_s == RUN);
            fault_o           <= (state_nxt_s == FAULT);
            retry_count_o     <= retry_nxt_s;
            lock_loss_count_o <= loss_nxt_s;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;

    logic       clk;
    logic       rst_n;
    logic       lock;
    logic       frc;
    logic       pll_reset_o;
    logic       sys_rst_n_o;
    logic       ready_o;
    logic       fault_o;
    logic [1:0] retry_count_o;
    logic [7:0] lock_loss_count_o;
    logic [13:0] got_s;

    int checks;
    int errors;
    int n;

    typedef struct {
        logic        lock;
        logic        frc;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[$];

    pll_lock_sequencer #(
        .SYNC_STAGES         (2),
        .PLL_RESET_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pll_lock_i        (lock),
        .force_relock_i    (frc),
        .pll_reset_o       (pll_reset_o),
        .sys_rst_n_o       (sys_rst_n_o),
        .ready_o           (ready_o),
        .fault_o           (fault_o),
        .retry_count_o     (retry_count_o),
        .lock_loss_count_o (lock_loss_count_o)
    );

    assign got_s = {pll_reset_o, sys_rst_n_o, ready_o, fault_o, retry_count_o, lock_loss_count_o};

    // Free-running reference clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [13:0] pk(input logic p, input logic s, input logic r,
                                       input logic f, input logic [1:0] rc,
                                       input logic [7:0] lc);
        return {p, s, r, f, rc, lc};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, got, exp);
        end
    endtask

    task automatic add(input logic l, input logic f, input logic p, input logic s,
                       input logic r, input logic ft, input logic [1:0] rc,
                       input logic [7:0] lc);
        vec_t v;
        v.lock = l;
        v.frc  = f;
        v.exp  = pk(p, s, r, ft, rc, lc);
        tbl.push_back(v);
    endtask

    // Row k: inputs applied at a falling edge, outputs compared after the next rising edge.
    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            lock = tbl[i].lock;
            frc  = tbl[i].frc;
            @(negedge clk);
            chk(name, i, {18'd0, got_s}, {18'd0, tbl[i].exp});
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        lock  = 1'b0;
        frc   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_values", 0, {18'd0, got_s}, {18'd0, pk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        lock   = 1'b0;
        frc    = 1'b0;

        // Clean bring-up: lock raised 10 cycles after release.
        do_reset();
        for (int k = 0; k < 25; k++) begin
            add(k >= 10, 1'b0, (k + 1) <= 3, (k + 1) >= 21, (k + 1) >= 21, 1'b0, 2'd0, 8'd0);
        end
        run_table("clean_bringup");

        // Glitchy lock: high 5, low 3, then high; STABLE restarts.
        do_reset();
        for (int k = 0; k < 31; k++) begin
            add(((k >= 10) && (k <= 14)) || (k >= 18), 1'b0, (k + 1) <= 3,
                (k + 1) >= 29, (k + 1) >= 29, 1'b0, 2'd0, 8'd0);
        end
        run_table("glitchy_lock");

        // No lock: three reset pulses, then FAULT.
        do_reset();
        for (int k = 0; k < 115; k++) begin
            int e;
            logic p;
            logic [1:0] rc;
            e  = k + 1;
            p  = (e <= 3) || ((e >= 36) && (e <= 39)) || ((e >= 72) && (e <= 75)) || (e >= 108);
            rc = (e >= 72) ? 2'd2 : ((e >= 36) ? 2'd1 : 2'd0);
            add(1'b0, 1'b0, p, 1'b0, 1'b0, e >= 108, rc, 8'd0);
        end
        run_table("no_lock");

        // Leave FAULT with a relock request, lock arrives right after.
        frc = 1'b1;
        @(negedge clk);
        chk("fault_exit", 0, {18'd0, got_s}, {18'd0, pk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
        frc  = 1'b0;
        lock = 1'b1;
        n = 1;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("relock_latency", 0, n, 14);
        chk("relock_run", 0, {18'd0, got_s}, {18'd0, pk(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0)});

        // Relock request on the same edge that would register a lock loss.
        lock = 1'b0;
        repeat (2) @(negedge clk);
        chk("run_before_loss", 0, {31'd0, ready_o}, 32'd1);
        frc = 1'b1;
        @(negedge clk);
        frc = 1'b0;
        chk("force_over_loss", 0, {18'd0, got_s}, {18'd0, pk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
        lock = 1'b1;
        n = 0;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rerun", 0, {31'd0, ready_o}, 32'd1);

        // Lock loss in RUN: reset within three cycles, counted, new pulse.
        lock = 1'b0;
        repeat (2) @(negedge clk);
        chk("loss_delay", 0, {18'd0, got_s}, {18'd0, pk(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0)});
        @(negedge clk);
        chk("loss_reset", 0, {18'd0, got_s}, {18'd0, pk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1)});
        repeat (3) @(negedge clk);
        chk("loss_pulse_end", 0, {31'd0, pll_reset_o}, 32'd1);
        @(negedge clk);
        chk("loss_pulse_off", 0, {18'd0, got_s}, {18'd0, pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1)});

        // Repeated losses saturate the counter at 255.
        for (int i = 2; i <= 300; i++) begin
            lock = 1'b1;
            n = 0;
            while (!ready_o && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("loss_relock", i, {31'd0, ready_o}, 32'd1);
            lock = 1'b0;
            n = 0;
            while (ready_o && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("loss_count", i, {24'd0, lock_loss_count_o}, (i > 255) ? 32'd255 : i);
        end

        // Relock request coincides with the final timeout at retry 2.
        do_reset();
        repeat (107) @(negedge clk);
        chk("pre_timeout", 0, {18'd0, got_s}, {18'd0, pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 8'd0)});
        frc = 1'b1;
        @(negedge clk);
        frc = 1'b0;
        chk("force_over_timeout", 0, {18'd0, got_s}, {18'd0, pk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
        repeat (3) @(negedge clk);
        chk("force_pulse_end", 0, {31'd0, pll_reset_o}, 32'd1);
        @(negedge clk);
        chk("force_pulse_off", 0, {31'd0, pll_reset_o}, 32'd0);

        // Asynchronous reset in the middle of STABLE.
        lock = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_stable", 0, {18'd0, got_s}, {18'd0, pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 0, {18'd0, got_s}, {18'd0, pk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
